mem_access_unit: RTL and testbench

- Requester-side controller that drives the Redux-V data_memory (8-bit address, 8-bit data, synchronous write, registered read).
- Accepts load/store requests from the core over a valid/ready handshake.
- Sequences the data_memory write_enable/address/data_in pins and returns load data or a store acknowledge over a valid/ready response channel.
- Sits between the core execute stage and data_memory; it is the only master of that memory.

---
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Requester-side controller for the Redux-V data_memory: takes one load/store
// at a time from the core, sequences the memory pins and returns data or an ack.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_is_store,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count
);

  localparam int unsigned LAT_W = 3;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("mem_access_unit: RD_LAT must be in 1..4");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. The unit keeps resp_valid/resp_is_store/resp_rdata stable until
  // that edge; req_ready is high only in IDLE, so at most one request is open.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // state_q is the FSM observation point for bound checkers.
  state_e              state_q, state_d;
  logic                op_q, op_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rv_q, rv_d;
  logic                is_store_q, is_store_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    lc_q, lc_d;
  logic [CNT_W-1:0]    sc_q, sc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      lat_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rv_q       <= 1'b0;
      is_store_q <= 1'b0;
      rdata_q    <= '0;
      lc_q       <= '0;
      sc_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      lat_q      <= lat_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rv_q       <= rv_d;
      is_store_q <= is_store_d;
      rdata_q    <= rdata_d;
      lc_q       <= lc_d;
      sc_q       <= sc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    lat_d      = lat_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rv_d       = rv_q;
    is_store_d = is_store_q;
    rdata_d    = rdata_q;
    lc_d       = lc_q;
    sc_d       = sc_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          op_d    = req_we;
          if (req_we) begin
            // Registered write strobe, so it is high for exactly the WRITE cycle.
            state_d = WRITE;
            we_d    = 1'b1;
          end else begin
            state_d = READ;
            lat_d   = LAT_W'(RD_LAT);
          end
        end
      end
      WRITE: begin
        state_d    = RESP;
        rv_d       = 1'b1;
        is_store_d = op_q;
        rdata_d    = '0;
        sc_d       = sc_q + CNT_W'(1);
      end
      READ: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          state_d    = RESP;
          rv_d       = 1'b1;
          is_store_d = op_q;
          rdata_d    = mem_data_out;
          lc_d       = lc_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst_n so the core sees no acceptance while reset is held.
  assign req_ready        = (state_q == IDLE) && rst_n;
  assign resp_valid       = rv_q;
  assign resp_is_store    = is_store_q;
  assign resp_rdata       = rdata_q;
  assign mem_write_enable = we_q;
  assign mem_address      = addr_q;
  assign mem_data_in      = wdata_q;
  assign load_count       = lc_q;
  assign store_count      = sc_q;

`ifndef SYNTHESIS
  a_we_only_in_write: assert property (@(posedge clk) disable iff (!rst_n)
    we_q |-> (state_q == WRITE));
  a_rv_only_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
    rv_q |-> (state_q == RESP));
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: an RD_LAT=1 instance on a writable memory model and
// an RD_LAT=3 instance on a pipelined read-only model, checked by scoreboards.
module tb_mem_access_unit;

  localparam int W = 13; // {is_store, latency[3:0], rdata[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT, RD_LAT = 1 ----------------
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_is_store;
  logic [7:0]  resp_rdata;
  logic        mem_we;
  logic [7:0]  mem_address, mem_data_in, mem_data_out;
  logic [15:0] load_count, store_count;

  mem_access_unit #(.RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_is_store(resp_is_store), .resp_rdata(resp_rdata),
    .mem_write_enable(mem_we), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .load_count(load_count), .store_count(store_count)
  );

  // ---------------- DUT, RD_LAT = 3 ----------------
  logic        req_valid3, req_ready3, req_we3;
  logic [7:0]  req_addr3, req_wdata3;
  logic        resp_valid3, resp_is_store3;
  logic        resp_ready3 = 1'b1;
  logic [7:0]  resp_rdata3;
  logic        mem_we3;
  logic [7:0]  mem_address3, mem_data_in3, mem_data_out3;
  logic [15:0] load_count3, store_count3;

  mem_access_unit #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3),
    .resp_is_store(resp_is_store3), .resp_rdata(resp_rdata3),
    .mem_write_enable(mem_we3), .mem_address(mem_address3),
    .mem_data_in(mem_data_in3), .mem_data_out(mem_data_out3),
    .load_count(load_count3), .store_count(store_count3)
  );

  // ---------------- memory models ----------------
  function automatic logic [7:0] init1(input logic [7:0] a);
    return a ^ 8'h3C;
  endfunction
  function automatic logic [7:0] init3(input logic [7:0] a);
    return a ^ 8'hC3;
  endfunction

  bit [7:0]   mem1 [256];
  bit [255:0] wr1;
  always @(posedge clk) begin
    if (mem_we) begin
      mem1[mem_address] <= mem_data_in;
      wr1[mem_address]  <= 1'b1;
    end
  end
  assign mem_data_out = wr1[mem_address] ? mem1[mem_address] : init1(mem_address);

  logic [7:0] p0, p1;
  always @(posedge clk) begin
    p0 <= init3(mem_address3);
    p1 <= p0;
  end
  assign mem_data_out3 = p1;

  // bench-side reference contents of memory 1
  bit [7:0]   ref_mem [256];
  bit [255:0] ref_wr;
  function automatic logic [7:0] ref_read(input logic [7:0] a);
    return ref_wr[a] ? ref_mem[a] : init1(a);
  endfunction

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboards / monitors ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp3_q[$];
  int           acc_cyc = 0;
  int           acc3 = 0;
  logic [7:0]   exp_waddr = 8'h00, exp_wdata = 8'h00;
  int           we_cnt = 0, we3_cnt = 0;
  logic         prev_rv = 1'b0, prev_rv3 = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] ent;
    if (mem_we) begin
      we_cnt++;
      check("wr_addr", mem_address, exp_waddr);
      check("wr_data", mem_data_in, exp_wdata);
    end
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", resp_valid, 1'b0);
      end else begin
        ent = exp_q[0];
        if (!prev_rv) check("latency", cyc - acc_cyc, ent[11:8]);
        if (resp_ready) begin
          ent = exp_q.pop_front();
          check("is_store", resp_is_store, ent[12]);
          check("rdata", resp_rdata, ent[7:0]);
        end
      end
    end
    prev_rv = resp_valid;
  end

  always @(negedge clk) begin
    logic [W-1:0] ent3;
    if (mem_we3) we3_cnt++;
    if (rst_n && resp_valid3) begin
      if (exp3_q.size() == 0) begin
        check("resp3_unexpected", resp_valid3, 1'b0);
      end else begin
        ent3 = exp3_q[0];
        if (!prev_rv3) check("latency3", cyc - acc3, ent3[11:8]);
        if (resp_ready3) begin
          ent3 = exp3_q.pop_front();
          check("is_store3", resp_is_store3, ent3[12]);
          check("rdata3", resp_rdata3, ent3[7:0]);
        end
      end
    end
    prev_rv3 = resp_valid3;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d,
                       input logic expect_resp);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    if (we) begin
      exp_waddr = a;
      exp_wdata = d;
    end
    acc_cyc = cyc + 1;
    if (expect_resp) begin
      exp_q.push_back({we, 4'd1, we ? 8'h00 : ref_read(a)});
      if (we) begin
        ref_mem[a] = d;
        ref_wr[a]  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic summary();
    $display("test done: total=%0d bad=%0d", total, bad);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int acc_prev;
    logic [7:0] a3;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    req_valid3 = 1'b0; req_we3 = 1'b0; req_addr3 = '0; req_wdata3 = '0;
    acc_prev = 0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_is_store", resp_is_store, 1'b0);
    check("rst_rdata", resp_rdata, 8'h00);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_address, 8'h00);
    check("rst_din", mem_data_in, 8'h00);
    check("rst_load_cnt", load_count, 16'd0);
    check("rst_store_cnt", store_count, 16'd0);
    rst_n = 1'b1;
    #1;
    check("req_ready_release", req_ready, 1'b1);

    // two stores
    issue(1'b1, 8'h0F, 8'hF0, 1'b1);
    issue(1'b1, 8'hF0, 8'h0F, 1'b1);
    wait_drain();
    check("store_count_2", store_count, 16'd2);
    check("we_pulses_2", we_cnt, 2);

    // two loads
    issue(1'b0, 8'h0F, 8'h00, 1'b1);
    issue(1'b0, 8'hF0, 8'h00, 1'b1);
    wait_drain();
    check("load_count_2", load_count, 16'd2);
    check("we_pulses_loads", we_cnt, 2);

    // overwrite then read back both locations
    issue(1'b1, 8'h0F, 8'hAA, 1'b1);
    issue(1'b0, 8'h0F, 8'h00, 1'b1);
    issue(1'b0, 8'hF0, 8'h00, 1'b1);
    wait_drain();
    check("we_pulses_3", we_cnt, 3);

    // backpressure
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    issue(1'b0, 8'h0F, 8'h00, 1'b1);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_resp_seen", resp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_hold", resp_valid, 1'b1);
      check("bp_rdata_hold", resp_rdata, 8'hAA);
      check("bp_req_ready", req_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_req_ready_after", req_ready, 1'b1);
    check("bp_valid_after", resp_valid, 1'b0);
    check("bp_load_count", load_count, 16'd5);
    check("bp_store_count", store_count, 16'd3);

    // reset in the WRITE cycle of a store
    issue(1'b1, 8'h20, 8'h55, 1'b0);
    check("mid_we_before_rst", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_we_rst", mem_we, 1'b0);
    check("mid_resp_valid", resp_valid, 1'b0);
    check("mid_store_count", store_count, 16'd0);
    check("mid_load_count", load_count, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_no_resp", resp_valid, 1'b0);
    check("mid_we_pulses", we_cnt, 3);
    issue(1'b0, 8'h20, 8'h00, 1'b1);
    wait_drain();
    check("post_rst_load_count", load_count, 16'd1);
    check("post_rst_store_count", store_count, 16'd0);

    // RD_LAT = 3 instance: back-to-back loads with req_valid held high
    for (int k = 0; k < 3; k++) begin
      n = 0;
      @(negedge clk);
      while (!req_ready3 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("req3_ready_wait", req_ready3, 1'b1);
      a3 = 8'(8'h11 * (k + 1));
      req_valid3 = 1'b1;
      req_we3    = 1'b0;
      req_addr3  = a3;
      acc3 = cyc + 1;
      if (k > 0) check("spacing3", acc3 - acc_prev, 5);
      acc_prev = acc3;
      exp3_q.push_back({1'b0, 4'd3, init3(a3)});
      @(posedge clk);
      #1;
    end
    req_valid3 = 1'b0;
    n = 0;
    while ((exp3_q.size() != 0 || !req_ready3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain3", exp3_q.size(), 0);
    check("load_count3", load_count3, 16'd3);
    check("we3_pulses", we3_cnt, 0);

    repeat (2) @(negedge clk);
    check("final_q_empty", exp_q.size(), 0);
    summary();
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    bad++;
    summary();
    $finish;
  end

endmodule
